// File: rtl/shift_sub_div_if.sv
// Operand/result handshake bundle for the shift-subtract divider.
// master drives operands and result acceptance; slave is the divider itself.
interface shift_sub_div_if #(
   parameter int BITS = 17
);
   logic                   in_valid;
   logic                   in_ready;
   logic signed [BITS-1:0] a;
   logic signed [BITS-1:0] b;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [BITS-1:0] q;
   logic                   ovf;
   logic                   dz;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, q, ovf, dz
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, q, ovf, dz
   );
endinterface

// File: rtl/shift_sub_div.sv
// Sequential signed fixed-point divider: q = (a << NFRAC) / b, restoring
// shift-subtract on magnitudes, one quotient bit per clock, sign applied last.
module shift_sub_div #(
   parameter int BITS  = 17,
   parameter int NFRAC = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   shift_sub_div_if.slave bus
);

   localparam int ITER  = BITS + NFRAC;
   localparam int CNT_W = $clog2(ITER + 1);
   localparam logic [CNT_W-1:0]       LAST  = CNT_W'(ITER - 1);
   localparam logic signed [BITS-1:0] Q_MAX = {1'b0, {(BITS-1){1'b1}}};
   localparam logic signed [BITS-1:0] Q_MIN = {1'b1, {(BITS-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                 state, state_nxt;
   logic [ITER-1:0]        num_p0;
   logic [BITS-1:0]        bmag_p0;
   logic [BITS:0]          rem_p0;
   logic [CNT_W-1:0]       cnt_p0;
   logic                   sign_p0;
   logic                   aneg_p0;
   logic                   dz_p0;
   logic signed [BITS-1:0] q_p1;
   logic                   ovf_p1;
   logic                   dz_p1;

   logic [BITS:0]          r_try;
   logic [BITS:0]          rem_nxt;
   logic                   geq;
   logic [ITER-1:0]        num_nxt;
   logic [BITS:0]          sat_res;

   // Magnitude of a two's-complement value; MIN maps to 2^(BITS-1) unsigned.
   function automatic logic [BITS-1:0] abs_mag(input logic signed [BITS-1:0] v);
      return v[BITS-1] ? (~v + 1'b1) : v;
   endfunction

   // Returns {ovf, q}: applies the sign and clamps the magnitude to the Q-format range.
   function automatic logic [BITS:0] saturate(input logic neg, input logic [ITER-1:0] mag);
      logic [ITER-1:0] pos_lim;
      logic [ITER-1:0] neg_lim;
      pos_lim = {{(NFRAC+1){1'b0}}, {(BITS-1){1'b1}}};
      neg_lim = {{NFRAC{1'b0}}, 1'b1, {(BITS-1){1'b0}}};
      if (!neg) begin
         if (mag > pos_lim) return {1'b1, Q_MAX};
         return {1'b0, mag[BITS-1:0]};
      end
      if (mag > neg_lim) return {1'b1, Q_MIN};
      return {1'b0, -mag[BITS-1:0]};
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = CALC;
         CALC:    if (dz_p0 || cnt_p0 == LAST) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: one restoring step; the numerator register doubles as quotient
   // shift register, so after ITER steps it holds the quotient magnitude.
   always_comb begin
      r_try   = {rem_p0[BITS-1:0], num_p0[ITER-1]};
      geq     = rem_p0[BITS] | (r_try >= {1'b0, bmag_p0});
      rem_nxt = geq ? (r_try - {1'b0, bmag_p0}) : r_try;
      num_nxt = {num_p0[ITER-2:0], geq};
      sat_res = saturate(sign_p0, num_nxt);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         num_p0  <= '0;
         bmag_p0 <= '0;
         rem_p0  <= '0;
         cnt_p0  <= '0;
         sign_p0 <= 1'b0;
         aneg_p0 <= 1'b0;
         dz_p0   <= 1'b0;
         q_p1    <= '0;
         ovf_p1  <= 1'b0;
         dz_p1   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  num_p0  <= {abs_mag(bus.a), {NFRAC{1'b0}}};
                  bmag_p0 <= abs_mag(bus.b);
                  sign_p0 <= bus.a[BITS-1] ^ bus.b[BITS-1];
                  aneg_p0 <= bus.a[BITS-1];
                  dz_p0   <= (bus.b == '0);
                  cnt_p0  <= '0;
                  rem_p0  <= '0;
               end
            end
            CALC: begin
               // Stage p1: result registers load on the final step only.
               if (dz_p0) begin
                  q_p1   <= aneg_p0 ? Q_MIN : Q_MAX;
                  ovf_p1 <= 1'b0;
                  dz_p1  <= 1'b1;
               end else begin
                  rem_p0 <= rem_nxt;
                  num_p0 <= num_nxt;
                  cnt_p0 <= cnt_p0 + 1'b1;
                  if (cnt_p0 == LAST) begin
                     q_p1   <= sat_res[BITS-1:0];
                     ovf_p1 <= sat_res[BITS];
                     dz_p1  <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.q         = q_p1;
   assign bus.ovf       = ovf_p1;
   assign bus.dz        = dz_p1;

endmodule
